// File: rtl/mem_data_req_ctrl.sv
// MEM-stage data-memory transaction controller: class-SRAM req/addr_ok/data_ok handshake.
// Optional `MEM_LOAD_EXTEND_EN: byte/half lane select and extension of load data done here.
module mem_data_req_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic        mem_req_en,
   input  logic        mem_wr,
   input  logic [1:0]  mem_size,
   input  logic        mem_signed_ext,
   input  logic [31:0] mem_addr,
   input  logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_wdata,
   input  logic        flush,
   output logic        data_sram_req,
   output logic        data_sram_wr,
   output logic [1:0]  data_sram_size,
   output logic [31:0] data_sram_addr,
   output logic [3:0]  data_sram_wstrb,
   output logic [31:0] data_sram_wdata,
   input  logic        data_sram_addr_ok,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   output logic        mem_ready_go,
   output logic [31:0] mem_dram_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t      state, state_nxt;
   logic        cancel, cancel_nxt;
   logic        accept;
   logic        capture;
   logic [31:0] rdata_q;

   assign accept = mem_valid & mem_req_en & ~flush & ~cancel;

   always_comb begin
      state_nxt  = state;
      cancel_nxt = cancel;
      capture    = 1'b0;
      case (state)
         S_IDLE: begin
            if (cancel) begin
               if (data_sram_data_ok) cancel_nxt = 1'b0;
            end else if (accept) begin
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (flush) cancel_nxt = 1'b1;
            if (data_sram_addr_ok) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // A flush coinciding with data_ok drops the response just like a sticky cancel.
            if (data_sram_data_ok) begin
               if (cancel | flush) begin
                  cancel_nxt = 1'b0;
                  state_nxt  = S_IDLE;
               end else begin
                  capture    = 1'b1;
                  state_nxt  = S_DONE;
               end
            end else if (flush) begin
               cancel_nxt = 1'b1;
            end
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= S_IDLE;
         cancel          <= 1'b0;
         data_sram_wr    <= 1'b0;
         data_sram_size  <= '0;
         data_sram_addr  <= '0;
         data_sram_wstrb <= '0;
         data_sram_wdata <= '0;
         rdata_q         <= '0;
      end else begin
         state  <= state_nxt;
         cancel <= cancel_nxt;
         if (state == S_IDLE && accept) begin
            data_sram_wr    <= mem_wr;
            data_sram_size  <= mem_size;
            data_sram_addr  <= mem_addr;
            data_sram_wstrb <= mem_wstrb;
            data_sram_wdata <= mem_wdata;
         end
         if (capture) rdata_q <= data_sram_wr ? '0 : data_sram_rdata;
      end
   end

   assign data_sram_req = (state == S_REQ);

   always_comb begin
      mem_ready_go = 1'b0;
      if (state == S_DONE)
         mem_ready_go = ~flush;
      else if (state == S_IDLE)
         mem_ready_go = ~(mem_valid & mem_req_en) & ~cancel;
   end

`ifdef MEM_LOAD_EXTEND_EN
   logic       sext_q;
   logic [1:0] addr_lo_q;
   logic [7:0] lane_b;
   logic [15:0] lane_h;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sext_q    <= 1'b0;
         addr_lo_q <= '0;
      end else if (state == S_IDLE && accept) begin
         sext_q    <= mem_signed_ext;
         addr_lo_q <= mem_addr[1:0];
      end
   end

   always_comb begin
      case (addr_lo_q)
         2'd0:    lane_b = rdata_q[7:0];
         2'd1:    lane_b = rdata_q[15:8];
         2'd2:    lane_b = rdata_q[23:16];
         default: lane_b = rdata_q[31:24];
      endcase
      lane_h = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (data_sram_size)
         2'd0:    mem_dram_rdata = {{24{sext_q & lane_b[7]}}, lane_b};
         2'd1:    mem_dram_rdata = {{16{sext_q & lane_h[15]}}, lane_h};
         default: mem_dram_rdata = rdata_q;
      endcase
   end
`else
   logic unused_sext;
   assign unused_sext    = mem_signed_ext;
   assign mem_dram_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_mem_data_req_ctrl.sv
// Scoreboard bench for mem_data_req_ctrl: scripted SRAM responder, latency and flush/reset checks.
module tb_mem_data_req_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_req_en, mem_wr, mem_signed_ext, flush;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        data_sram_req, data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [31:0] data_sram_addr, data_sram_wdata;
   logic [3:0]  data_sram_wstrb;
   logic        data_sram_addr_ok, data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        mem_ready_go;
   logic [31:0] mem_dram_rdata;

   int unsigned checks = 0;
   int unsigned failures = 0;
   logic [31:0] sb_q[$];

`ifdef MEM_LOAD_EXTEND_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   always #5 clk = ~clk;

   mem_data_req_ctrl dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_req_en(mem_req_en), .mem_wr(mem_wr),
      .mem_size(mem_size), .mem_signed_ext(mem_signed_ext), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .flush(flush),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
      .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata),
      .mem_ready_go(mem_ready_go), .mem_dram_rdata(mem_dram_rdata)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wr, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
      mem_valid = 1'b1; mem_req_en = 1'b1; mem_wr = wr; mem_size = size;
      mem_signed_ext = sext; mem_addr = addr; mem_wstrb = wstrb; mem_wdata = wdata;
   endtask

   // Called at posedge+1; the current cycle is the accept cycle (cycle 0).
   task automatic do_op(input logic wr, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int unsigned a_dly, input int unsigned d_dly,
                        input logic [31:0] exp);
      bit got = 1'b0;
      drive(wr, size, sext, addr, wstrb, wdata);
      sb_q.push_back(exp);
      for (int unsigned cyc = 0; cyc < 40 && !got; cyc++) begin
         data_sram_addr_ok = data_sram_req && (cyc == 1 + a_dly);
         data_sram_data_ok = (cyc == 2 + a_dly + d_dly);
         data_sram_rdata   = data_sram_data_ok ? rdata : 32'hA5A5_A5A5;
         check_eq("req", {31'd0, data_sram_req}, {31'd0, (cyc >= 1 && cyc <= 1 + a_dly)});
         if (data_sram_req) begin
            check_eq("addr", data_sram_addr, addr);
            check_eq("wdata", data_sram_wdata, wdata);
            check_eq("ctl", {25'd0, data_sram_wr, data_sram_size, data_sram_wstrb},
                     {25'd0, wr, size, wstrb});
         end
         @(negedge clk);
         if (mem_ready_go) begin
            got = 1'b1;
            check_eq("latency", cyc, 3 + a_dly + d_dly);
            check_eq("sb_pending", sb_q.size(), 1);
            if (sb_q.size() != 0) check_eq("rdata", mem_dram_rdata, sb_q.pop_front());
         end
         next_cycle();
      end
      check_eq("done_seen", {31'd0, got}, 32'd1);
      mem_valid = 1'b0; mem_req_en = 1'b0;
      data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      mem_valid = 1'b0; mem_req_en = 1'b0; mem_wr = 1'b0; mem_size = '0;
      mem_signed_ext = 1'b0; mem_addr = '0; mem_wstrb = '0; mem_wdata = '0;
      data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
      #12;
      check_eq("rst_req", {31'd0, data_sram_req}, 32'd0);
      check_eq("rst_addr", data_sram_addr, 32'd0);
      check_eq("rst_wdata", data_sram_wdata, 32'd0);
      check_eq("rst_ctl", {25'd0, data_sram_wr, data_sram_size, data_sram_wstrb}, 32'd0);
      check_eq("rst_rdata", mem_dram_rdata, 32'd0);
      check_eq("rst_ready", {31'd0, mem_ready_go}, 32'd1);
      next_cycle();
      rst = 1'b0;
      next_cycle();

      // loads: word, byte/half lanes with sign and zero extension
      do_op(1'b0, 2'd2, 1'b0, 32'h1000, 4'h0, 32'h0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
      do_op(1'b0, 2'd0, 1'b1, 32'h1003, 4'h0, 32'h0, 32'h80112233, 0, 0,
            EXT ? 32'hFFFFFF80 : 32'h80112233);
      do_op(1'b0, 2'd0, 1'b0, 32'h1003, 4'h0, 32'h0, 32'h80112233, 0, 1,
            EXT ? 32'h00000080 : 32'h80112233);
      do_op(1'b0, 2'd1, 1'b1, 32'h1002, 4'h0, 32'h0, 32'h80112233, 1, 0,
            EXT ? 32'hFFFF8011 : 32'h80112233);
      do_op(1'b0, 2'd1, 1'b1, 32'h1000, 4'h0, 32'h0, 32'h80112233, 0, 0,
            EXT ? 32'h00002233 : 32'h80112233);
      do_op(1'b0, 2'd0, 1'b1, 32'h1001, 4'h0, 32'h0, 32'h80112233, 0, 0,
            EXT ? 32'h00000022 : 32'h80112233);
      // stores: delayed addr_ok, result data is zero
      do_op(1'b1, 2'd2, 1'b0, 32'h1004, 4'hF, 32'hCAFEF00D, 32'h0, 3, 0, 32'h0);
      do_op(1'b1, 2'd0, 1'b0, 32'h1001, 4'h2, 32'h0000AB00, 32'h0, 1, 2, 32'h0);

      // non-memory instruction passes with zero latency
      mem_valid = 1'b1; mem_req_en = 1'b0;
      @(negedge clk);
      check_eq("nomem_ready", {31'd0, mem_ready_go}, 32'd1);
      check_eq("nomem_req", {31'd0, data_sram_req}, 32'd0);
      next_cycle();
      check_eq("nomem_req2", {31'd0, data_sram_req}, 32'd0);
      mem_valid = 1'b0;

      // flush in WAIT, data_ok 4 cycles later, new load presented meanwhile
      drive(1'b0, 2'd2, 1'b0, 32'h2000, 4'h0, 32'h0);
      @(negedge clk);
      check_eq("fw_acc_ready", {31'd0, mem_ready_go}, 32'd0);
      next_cycle();
      check_eq("fw_req", {31'd0, data_sram_req}, 32'd1);
      data_sram_addr_ok = 1'b1;
      next_cycle();
      data_sram_addr_ok = 1'b0; flush = 1'b1;
      @(negedge clk);
      check_eq("fw_flush_ready", {31'd0, mem_ready_go}, 32'd0);
      next_cycle();
      flush = 1'b0;
      drive(1'b0, 2'd2, 1'b0, 32'h3000, 4'h0, 32'h0);
      for (int k = 3; k <= 6; k++) begin
         data_sram_data_ok = (k == 6);
         data_sram_rdata   = 32'h1111_1111;
         check_eq("fw_hold_req", {31'd0, data_sram_req}, 32'd0);
         @(negedge clk);
         check_eq("fw_hold_ready", {31'd0, mem_ready_go}, 32'd0);
         next_cycle();
      end
      data_sram_data_ok = 1'b0;
      do_op(1'b0, 2'd2, 1'b0, 32'h3000, 4'h0, 32'h0, 32'h12345678, 0, 0, 32'h12345678);

      // flush during REQ with addr_ok held low for 2 cycles
      drive(1'b0, 2'd2, 1'b0, 32'h4000, 4'h0, 32'h0);
      next_cycle();
      flush = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         data_sram_addr_ok = (k == 3);
         data_sram_data_ok = (k == 5);
         data_sram_rdata   = 32'h2222_2222;
         check_eq("fr_req", {31'd0, data_sram_req}, {31'd0, (k <= 3)});
         @(negedge clk);
         check_eq("fr_ready", {31'd0, mem_ready_go}, {31'd0, (k == 6)});
         next_cycle();
         flush = 1'b0; mem_valid = 1'b0; mem_req_en = 1'b0;
      end
      data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;

      // flush in DONE suppresses mem_ready_go
      drive(1'b0, 2'd2, 1'b0, 32'h5000, 4'h0, 32'h0);
      next_cycle();
      data_sram_addr_ok = 1'b1;
      next_cycle();
      data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h3333_3333;
      next_cycle();
      data_sram_data_ok = 1'b0; flush = 1'b1;
      @(negedge clk);
      check_eq("fd_ready", {31'd0, mem_ready_go}, 32'd0);
      next_cycle();
      flush = 1'b0; mem_valid = 1'b0; mem_req_en = 1'b0;
      @(negedge clk);
      check_eq("fd_idle_ready", {31'd0, mem_ready_go}, 32'd1);
      check_eq("fd_idle_req", {31'd0, data_sram_req}, 32'd0);
      next_cycle();

      // asynchronous reset while in REQ
      drive(1'b1, 2'd2, 1'b0, 32'h6000, 4'hF, 32'h77777777);
      next_cycle();
      check_eq("ar_req_before", {31'd0, data_sram_req}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check_eq("ar_req", {31'd0, data_sram_req}, 32'd0);
      check_eq("ar_addr", data_sram_addr, 32'd0);
      mem_valid = 1'b0; mem_req_en = 1'b0;
      @(negedge clk);
      check_eq("ar_ready", {31'd0, mem_ready_go}, 32'd1);
      next_cycle();
      rst = 1'b0;
      next_cycle();

      // asynchronous reset while in WAIT, then a clean transaction
      drive(1'b0, 2'd2, 1'b0, 32'h7000, 4'h0, 32'h0);
      next_cycle();
      data_sram_addr_ok = 1'b1;
      next_cycle();
      data_sram_addr_ok = 1'b0;
      #1 rst = 1'b1;
      #1;
      check_eq("aw_req", {31'd0, data_sram_req}, 32'd0);
      mem_valid = 1'b0; mem_req_en = 1'b0;
      next_cycle();
      rst = 1'b0;
      next_cycle();
      do_op(1'b0, 2'd2, 1'b0, 32'h8000, 4'h0, 32'h0, 32'h0BADF00D, 2, 3, 32'h0BADF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
